// File: rtl/echo_indication_queue.sv
// echo_indication_queue
//   Downstream stage of the echo block. Each heard(v) indication is tagged
//   with a running sequence number, buffered in a small circular FIFO and
//   forwarded to the host indication port msg(seq, v). Host backpressure is
//   absorbed by the FIFO, and delivered indications are counted.
//
// Ports
//   CLK         clock, all state on rising edge
//   nRST        asynchronous active-low reset
//   heard__ENA  enqueue strobe from echo (legal only while heard__RDY=1)
//   heard_v     32-bit value carried by heard
//   heard__RDY  1 when FIFO not full
//   msg__ENA    host indication msg invoked this cycle
//   msg_seq     sequence tag of head entry (0 while empty)
//   msg_v       value of head entry (0 while empty)
//   msg__RDY    host can accept msg this cycle
//   count       msg invocations since reset, saturating at 16'hFFFF
//   empty       FIFO empty
//   full        FIFO full
module echo_indication_queue #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             heard__ENA,
  input  logic [31:0]      heard_v,
  output logic             heard__RDY,
  output logic             msg__ENA,
  output logic [SEQ_W-1:0] msg_seq,
  output logic [31:0]      msg_v,
  input  logic             msg__RDY,
  output logic [15:0]      count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = SEQ_W + 32;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   occ;
  logic [SEQ_W-1:0] seq;
  logic [ENT_W-1:0] head;
  logic             do_enq;
  logic             do_deq;

  // Flags come from registered occupancy only, so heard__RDY never depends
  // combinationally on heard__ENA; msg__RDY reaches only msg__ENA.
  assign empty      = (occ == '0);
  assign full       = (occ == OCC_FULL);
  assign heard__RDY = !full;
  assign msg__ENA   = !empty && msg__RDY;

  // An enqueue while full is dropped without consuming a sequence number.
  assign do_enq = heard__ENA && !full;
  assign do_deq = msg__ENA;

  assign head    = mem[rd_ptr];
  assign msg_seq = empty ? '0 : head[ENT_W-1:32];
  assign msg_v   = empty ? '0 : head[31:0];

  // Storage write stage: contents are not reset, empty masks stale data.
  always_ff @(posedge CLK) begin
    if (do_enq) begin
      mem[wr_ptr] <= {seq, heard_v};
    end
  end

  // Control state stage: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      seq    <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        seq    <= seq + SEQ_ONE;
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (count != 16'hFFFF) begin
          count <= count + 16'd1;
        end
      end
      case ({do_enq, do_deq})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_indication_queue.sv
module tb_echo_indication_queue;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;
  localparam int ENT_W = SEQ_W + 32;

  logic             CLK;
  logic             nRST;
  logic             heard__ENA;
  logic [31:0]      heard_v;
  logic             heard__RDY;
  logic             msg__ENA;
  logic [SEQ_W-1:0] msg_seq;
  logic [31:0]      msg_v;
  logic             msg__RDY;
  logic [15:0]      count;
  logic             empty;
  logic             full;

  echo_indication_queue #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .heard__ENA (heard__ENA),
    .heard_v    (heard_v),
    .heard__RDY (heard__RDY),
    .msg__ENA   (msg__ENA),
    .msg_seq    (msg_seq),
    .msg_v      (msg_v),
    .msg__RDY   (msg__RDY),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the queue holds exactly what the FIFO should contain.
  logic [ENT_W-1:0] sb[$];
  logic [ENT_W-1:0] pend;
  logic             pend_vld;
  logic [SEQ_W-1:0] seq_m;
  logic [15:0]      cnt_m;
  int               n_deq;
  int               n_chk;
  int               n_fail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops whenever the DUT delivers.
  always @(negedge CLK) begin
    if (nRST) begin
      chk("heard_rdy", 64'(heard__RDY), 64'(sb.size() < DEPTH));
      chk("msg_ena",   64'(msg__ENA),   64'(sb.size() > 0 && msg__RDY));
      chk("empty",     64'(empty),      64'(sb.size() == 0));
      chk("full",      64'(full),       64'(sb.size() == DEPTH));
      chk("count",     64'(count),      64'(cnt_m));
      if (sb.size() == 0) begin
        chk("msg_v_empty", 64'(msg_v), 64'd0);
      end
      if (msg__ENA) begin
        if (sb.size() == 0) begin
          chk("unexpected_msg", 64'(msg_v), 64'd0 - 64'd1);
        end else begin
          logic [ENT_W-1:0] e;
          e = sb.pop_front();
          chk("msg_seq", 64'(msg_seq), 64'(e[ENT_W-1:32]));
          chk("msg_v",   64'(msg_v),   64'(e[31:0]));
          if (cnt_m != 16'hFFFF) cnt_m++;
          n_deq++;
        end
      end
    end
  end

  // One clock of stimulus; a pending accept becomes FIFO content after the edge.
  task automatic cycle(input logic ena, input logic [31:0] v, input logic rdy);
    @(posedge CLK);
    if (pend_vld) begin
      sb.push_back(pend);
      pend_vld = 1'b0;
    end
    #1;
    heard__ENA = ena;
    heard_v    = v;
    msg__RDY   = rdy;
    if (ena && sb.size() < DEPTH) begin
      pend     = {seq_m, v};
      pend_vld = 1'b1;
      seq_m    = seq_m + 1'b1;
    end
  endtask

  // Asynchronous reset asserted between edges, with msg__RDY raised at once.
  task automatic do_reset();
    @(posedge CLK);
    #3;
    nRST       = 1'b0;
    msg__RDY   = 1'b1;
    heard__ENA = 1'b0;
    #1;
    chk("rst_msg_ena", 64'(msg__ENA),   64'd0);
    chk("rst_count",   64'(count),      64'd0);
    chk("rst_empty",   64'(empty),      64'd1);
    chk("rst_full",    64'(full),       64'd0);
    chk("rst_rdy",     64'(heard__RDY), 64'd1);
    chk("rst_seq",     64'(msg_seq),    64'd0);
    chk("rst_v",       64'(msg_v),      64'd0);
    sb.delete();
    pend_vld = 1'b0;
    seq_m    = '0;
    cnt_m    = '0;
    n_deq    = 0;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    nRST = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() > 0 || pend_vld); i++) cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_deq = 0;
    seq_m = '0; cnt_m = '0; pend_vld = 1'b0; pend = '0;
    heard__ENA = 1'b0; heard_v = '0; msg__RDY = 1'b1;
    nRST = 1'b0;
    #2;
    chk("init_rdy",     64'(heard__RDY), 64'd1);
    chk("init_msg_ena", 64'(msg__ENA),   64'd0);
    chk("init_empty",   64'(empty),      64'd1);
    chk("init_full",    64'(full),       64'd0);
    chk("init_count",   64'(count),      64'd0);
    chk("init_seq",     64'(msg_seq),    64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    nRST = 1'b1;

    // Single transfer, seq 0.
    cycle(1'b1, 32'h1111_1111, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    @(negedge CLK);
    #1;
    chk("t1_count", 64'(count), 64'd1);

    // Fill under backpressure, fifth enqueue dropped, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    @(negedge CLK);
    #1;
    chk("t2_full", 64'(full),       64'd1);
    chk("t2_rdy",  64'(heard__RDY), 64'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);

    // Full FIFO with both strobes held high.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b1);
    drain();

    // Streaming 300 values, seq wraps.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 32'h5000 + 32'(i), 1'b1);
    drain();
    @(negedge CLK);
    #1;
    chk("t4_count", 64'(count), 64'd300);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    do_reset();
    cycle(1'b1, 32'hE0, 1'b1);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 55));
    end
    drain();
    @(negedge CLK);
    #1;
    chk("rand_count", 64'(count), 64'(n_deq));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
